pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: fetch_valid  in  1  IF stage holds a real instruction this cycle.
REQ-004 SHALL expose: id_rs1_addr, id_rs2_addr  in  5 each  ID source register indices.
REQ-005 SHALL expose: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-006 SHALL expose: ex_is_load, ex_rd_addr  in  1, 5  EX instruction is a load and its destination.
REQ-007 SHALL expose: ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 SHALL expose: mem_stall  in  1  data memory not ready; whole pipeline freezes.
REQ-009 SHALL expose: pc_stall, ifid_stall, ifid_flush, idex_flush  out  1 each  pipeline register controls.
REQ-010 SHALL expose: lw_use  out  1  load-use bubble inserted this cycle; feeds csr.
REQ-011 SHALL expose: branch  out  2  number of valid instructions squashed this cycle (0..2); feeds csr.
REQ-012 SHALL expose: retire_valid  out  1  a valid instruction completes WB this cycle.
REQ-013 SHALL expose: stall_cnt, flush_cnt  out  32 each  perf counters (see Configuration).

Function
REQ-014 SHALL hold valid bits v_id, v_ex, v_mem, v_wb; reset value 0.
REQ-015 SHALL qualify hazards with valid bits: load-use hit = v_id & v_ex & ex_is_load & ex_rd_addr!=0 & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)); taken = v_ex & ex_branch_taken.
REQ-016 SHALL give priority mem_stall > taken > load-use hit.
REQ-017 SHALL, on mem_stall: hold all valid bits; pc_stall=ifid_stall=1; ifid_flush=idex_flush=0; lw_use=0; branch=0; retire_valid=0.
REQ-018 SHALL, on taken (no mem_stall): ifid_flush=idex_flush=1; pc_stall=ifid_stall=0; branch = v_id + fetch_valid (2-bit sum); lw_use=0; next v_id=0, v_ex=0.
REQ-019 SHALL, on load-use hit (no mem_stall, no taken): pc_stall=ifid_stall=idex_flush=1; lw_use=1; branch=0; next v_id held, v_ex=0.
REQ-020 SHALL, otherwise: all control outputs 0; next v_id=fetch_valid, v_ex=v_id.
REQ-021 SHALL advance v_mem<=v_ex, v_wb<=v_mem whenever mem_stall=0.
REQ-022 SHALL drive retire_valid = v_wb & ~mem_stall, combinational from registered state; exactly one pulse per retired instruction.
REQ-023 SHALL drive all hazard outputs combinationally in the same cycle as the detecting inputs (zero latency).
REQ-024 SHALL never detect a hazard against x0 or against a bubble (v_ex=0).

Reset
REQ-025 SHALL clear all valid bits and counters immediately on rst high, independent of clk.
REQ-026 SHALL produce all outputs 0 while rst is high; mid-operation reset discards in-flight instructions with no retire pulse.
REQ-027 SHALL resume normal sequencing on the first rising clk after rst falls.

Configuration
REQ-028 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cnt each cycle pc_stall=1 and flush_cnt each cycle ifid_flush=1, both saturating at 32'hFFFF_FFFF.
REQ-029 SHALL, without PIPE_CTRL_PERF_EN, tie stall_cnt and flush_cnt to 0 and instantiate no counter registers.

Verification
REQ-030 SHALL cover: fetch_valid=1 for 6 cycles, no hazards -> retire_valid first high 4 cycles after first fetch, then high for 6 consecutive cycles.
REQ-031 SHALL cover: EX lw x5, ID add x6,x5,x1 (uses_rs1, rs1=5) -> lw_use=1, pc_stall=ifid_stall=idex_flush=1 for one cycle; ID instruction retires one cycle late.
REQ-032 SHALL cover: ex_branch_taken=1 with v_id=1, fetch_valid=1 -> branch=2'd2, ifid_flush=idex_flush=1; next cycle v_id=v_ex=0; only 2 fewer retire pulses.
REQ-033 SHALL cover: load-use hit and taken same cycle -> branch taken path only, lw_use=0; load with ex_rd_addr=0 -> no stall.
REQ-034 SHALL cover: mem_stall=1 for 3 cycles mid-stream -> valid bits frozen, retire_valid=0, no instruction lost or duplicated after release; with PIPE_CTRL_PERF_EN stall_cnt +3.
REQ-035 SHALL cover: rst pulse asynchronous between edges with 4 valid in flight -> all outputs 0 immediately, no retire pulse until new fetches reach WB.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard and valid-bit controller for a 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_branch_taken,
  input  logic        mem_stall,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        lw_use,
  output logic [1:0]  branch,
  output logic        retire_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic v_id_q, v_id_d;
  logic v_ex_q, v_ex_d;
  logic v_mem_q, v_mem_d;
  logic v_wb_q, v_wb_d;

  logic lu_hit;
  logic taken;

  // Hazards only count against real instructions and never against x0.
  assign lu_hit = v_id_q & v_ex_q & ex_is_load & (ex_rd_addr != 5'd0) &
                  ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                   (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
  assign taken  = v_ex_q & ex_branch_taken;

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    v_id_d       = v_id_q;
    v_ex_d       = v_ex_q;
    v_mem_d      = v_mem_q;
    v_wb_d       = v_wb_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    lw_use       = 1'b0;
    branch       = 2'd0;
    retire_valid = 1'b0;

    if (mem_stall) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else begin
      v_mem_d      = v_ex_q;
      v_wb_d       = v_mem_q;
      retire_valid = v_wb_q;
      if (taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        branch     = {1'b0, v_id_q} + {1'b0, fetch_valid};
        v_id_d     = 1'b0;
        v_ex_d     = 1'b0;
      end else if (lu_hit) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        lw_use     = 1'b1;
        v_ex_d     = 1'b0;
      end else begin
        v_id_d = fetch_valid;
        v_ex_d = v_id_q;
      end
    end

    // Outputs are quiet for the whole reset window, whatever the inputs do.
    if (rst) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      lw_use       = 1'b0;
      branch       = 2'd0;
      retire_valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_mem_q <= 1'b0;
      v_wb_q  <= 1'b0;
    end else begin
      v_id_q  <= v_id_d;
      v_ex_q  <= v_ex_d;
      v_mem_q <= v_mem_d;
      v_wb_q  <= v_wb_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
